// File: rtl/hdmi_pkg.sv
// Shared definitions for the HDMI period scheduler.
//   - mode_e         : channel period encoding carried on the mode output
//   - DEF_*          : default 640x480@60 raster timing
//   - PREAMBLE_LEN / GUARD_LEN : length of the pre-video periods
//   - CTL_VIDEO_PRE  : CTL3..CTL0 during a video preamble
//   - GUARD_CH*      : TMDS video guard-band characters for the encoder
// Build option: HDMI_GUARD_BAND_EN (see hdmi_period_scheduler.sv).
package hdmi_pkg;

  typedef enum logic [1:0] {
    MODE_CONTROL  = 2'd0,
    MODE_PREAMBLE = 2'd1,
    MODE_GUARD    = 2'd2,
    MODE_VIDEO    = 2'd3
  } mode_e;

  localparam int DEF_H_ACTIVE     = 640;
  localparam int DEF_H_TOTAL      = 800;
  localparam int DEF_H_SYNC_START = 656;
  localparam int DEF_H_SYNC_END   = 752;
  localparam int DEF_V_ACTIVE     = 480;
  localparam int DEF_V_TOTAL      = 525;
  localparam int DEF_V_SYNC_START = 490;
  localparam int DEF_V_SYNC_END   = 492;

  // Preamble occupies the 8 clocks before the 2 guard clocks that end a line.
  localparam int PREAMBLE_LEN = 8;
  localparam int GUARD_LEN    = 2;

  localparam logic [3:0] CTL_VIDEO_PRE = 4'b0001;

  // Guard-band characters: channels 0 and 2 share one, channel 1 differs.
  localparam logic [9:0] GUARD_CH0_CH2 = 10'b1011001100;
  localparam logic [9:0] GUARD_CH1     = 10'b0100110011;

endpackage

// File: rtl/hdmi_raster_counter.sv
// Raster position counter.
//   i_clk    : pixel clock
//   i_rst    : asynchronous active-high reset, clears the position to (0,0)
//   i_enable : advance one pixel per cycle when high, hold when low
//   o_cx     : horizontal position 0..H_TOTAL-1
//   o_cy     : vertical position 0..V_TOTAL-1, steps when o_cx wraps
module hdmi_raster_counter #(
  parameter int H_TOTAL = 800,
  parameter int V_TOTAL = 525
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_enable,
  output logic [9:0] o_cx,
  output logic [9:0] o_cy
);

  logic [9:0] r_cx;
  logic [9:0] r_cy;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cx <= '0;
      r_cy <= '0;
    end else if (i_enable) begin
      if (r_cx == 10'(H_TOTAL - 1)) begin
        r_cx <= '0;
        r_cy <= (r_cy == 10'(V_TOTAL - 1)) ? '0 : r_cy + 10'd1;
      end else begin
        r_cx <= r_cx + 10'd1;
      end
    end
  end

  assign o_cx = r_cx;
  assign o_cy = r_cy;

endmodule

// File: rtl/hdmi_period_scheduler.sv
// HDMI channel period scheduler: walks the raster and tells the TMDS encoder
// which period (control, preamble, guard band, video) each pixel clock is.
//   pixclk      : pixel clock, the only clock
//   rst         : asynchronous active-high reset
//   enable      : raster advance enable; low holds position and idles outputs
//   mode        : CONTROL=0, PREAMBLE=1, GUARD=2, VIDEO=3
//   ctl         : CTL3..CTL0 for channels 1/2 during control periods
//   hsync/vsync : sync levels for channel 0 control data
//   pix_x/pix_y : raster coordinate matching the current mode
//   frame_start : one-cycle pulse on the (0,0) output
// All outputs are registered and lag the raster counter by one cycle.
// Build option: define HDMI_GUARD_BAND_EN to emit preamble and guard-band
// periods ahead of each active line; without it (DVI) those clocks stay
// CONTROL with ctl=0.
module hdmi_period_scheduler
  import hdmi_pkg::*;
#(
  parameter int H_ACTIVE     = DEF_H_ACTIVE,
  parameter int H_TOTAL      = DEF_H_TOTAL,
  parameter int H_SYNC_START = DEF_H_SYNC_START,
  parameter int H_SYNC_END   = DEF_H_SYNC_END,
  parameter int V_ACTIVE     = DEF_V_ACTIVE,
  parameter int V_TOTAL      = DEF_V_TOTAL,
  parameter int V_SYNC_START = DEF_V_SYNC_START,
  parameter int V_SYNC_END   = DEF_V_SYNC_END
) (
  input  logic       pixclk,
  input  logic       rst,
  input  logic       enable,
  output logic [1:0] mode,
  output logic [3:0] ctl,
  output logic       hsync,
  output logic       vsync,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       frame_start
);

  logic [9:0] w_cx;
  logic [9:0] w_cy;
  logic       w_video;
  logic       w_hsync;
  logic       w_vsync;
  logic       w_frame_start;
  logic       w_preamble;
  logic       w_guard;
  mode_e      w_mode;
  logic [3:0] w_ctl;

  mode_e      r_mode;
  logic [3:0] r_ctl;
  logic       r_hsync;
  logic       r_vsync;
  logic [9:0] r_pix_x;
  logic [9:0] r_pix_y;
  logic       r_frame_start;

  hdmi_raster_counter #(
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL)
  ) u_counter (
    .i_clk    (pixclk),
    .i_rst    (rst),
    .i_enable (enable),
    .o_cx     (w_cx),
    .o_cy     (w_cy)
  );

  assign w_video       = (w_cx < 10'(H_ACTIVE)) && (w_cy < 10'(V_ACTIVE));
  assign w_hsync       = (w_cx >= 10'(H_SYNC_START)) && (w_cx < 10'(H_SYNC_END));
  assign w_vsync       = (w_cy >= 10'(V_SYNC_START)) && (w_cy < 10'(V_SYNC_END));
  assign w_frame_start = (w_cx == 10'd0) && (w_cy == 10'd0);

`ifdef HDMI_GUARD_BAND_EN
  // The last line of the frame counts as preceding active line 0, so the
  // vertical wrap is applied before the active test.
  logic [9:0] w_cy_next;
  logic       w_next_active;

  assign w_cy_next     = (w_cy == 10'(V_TOTAL - 1)) ? 10'd0 : w_cy + 10'd1;
  assign w_next_active = w_cy_next < 10'(V_ACTIVE);
  assign w_preamble    = w_next_active
                         && (w_cx >= 10'(H_TOTAL - PREAMBLE_LEN - GUARD_LEN))
                         && (w_cx <  10'(H_TOTAL - GUARD_LEN));
  assign w_guard       = w_next_active && (w_cx >= 10'(H_TOTAL - GUARD_LEN));
`else
  assign w_preamble    = 1'b0;
  assign w_guard       = 1'b0;
`endif

  always_comb begin
    w_mode = MODE_CONTROL;
    w_ctl  = 4'd0;
    if (w_video) begin
      w_mode = MODE_VIDEO;
    end else if (w_preamble) begin
      w_mode = MODE_PREAMBLE;
      w_ctl  = CTL_VIDEO_PRE;
    end else if (w_guard) begin
      w_mode = MODE_GUARD;
    end
  end

  // Coordinates always track the (possibly held) counter; the period and
  // sync outputs idle while the raster is paused.
  always_ff @(posedge pixclk or posedge rst) begin
    if (rst) begin
      r_mode        <= MODE_CONTROL;
      r_ctl         <= '0;
      r_hsync       <= 1'b0;
      r_vsync       <= 1'b0;
      r_pix_x       <= '0;
      r_pix_y       <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_pix_x <= w_cx;
      r_pix_y <= w_cy;
      if (enable) begin
        r_mode        <= w_mode;
        r_ctl         <= w_ctl;
        r_hsync       <= w_hsync;
        r_vsync       <= w_vsync;
        r_frame_start <= w_frame_start;
      end else begin
        r_mode        <= MODE_CONTROL;
        r_ctl         <= '0;
        r_hsync       <= 1'b0;
        r_vsync       <= 1'b0;
        r_frame_start <= 1'b0;
      end
    end
  end

  assign mode        = r_mode;
  assign ctl         = r_ctl;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign pix_x       = r_pix_x;
  assign pix_y       = r_pix_y;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// Bench for hdmi_period_scheduler. Two instances share clock, reset and
// enable: u_dut at the default 640x480 timing, and u_small with a compact
// raster (32x10) so whole frames, frame wrap and vsync fit in a short run.
// Every output cycle of both is compared to a reference model that derives
// the expected period from a linear pixel index; a table of fixed raster
// points with hand-derived expectations is checked as the stream passes.
module tb_hdmi_period_scheduler;

  typedef struct {
    int ha; int ht; int hs0; int hs1; int va; int vt; int vs0; int vs1;
  } timing_t;

  typedef struct {
    logic [1:0] mode; logic [3:0] ctl; logic hs; logic vs; logic fs;
    int px; int py; bit en;
  } exp_t;

  typedef struct {
    int inst; int x; int y;
    logic [1:0] mode; logic [3:0] ctl; logic hs; logic vs; int hits;
  } vec_t;

`ifdef HDMI_GUARD_BAND_EN
  localparam bit GB = 1'b1;
`else
  localparam bit GB = 1'b0;
`endif

  localparam timing_t TD = '{640, 800, 656, 752, 480, 525, 490, 492};
  localparam timing_t TS = '{16, 32, 20, 24, 6, 10, 7, 9};

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] d_mode, s_mode;
  logic [3:0] d_ctl, s_ctl;
  logic       d_hs, d_vs, d_fs, s_hs, s_vs, s_fs;
  logic [9:0] d_px, d_py, s_px, s_py;

  hdmi_period_scheduler u_dut (
    .pixclk(clk), .rst(rst), .enable(enable),
    .mode(d_mode), .ctl(d_ctl), .hsync(d_hs), .vsync(d_vs),
    .pix_x(d_px), .pix_y(d_py), .frame_start(d_fs)
  );

  hdmi_period_scheduler #(
    .H_ACTIVE(16), .H_TOTAL(32), .H_SYNC_START(20), .H_SYNC_END(24),
    .V_ACTIVE(6), .V_TOTAL(10), .V_SYNC_START(7), .V_SYNC_END(9)
  ) u_small (
    .pixclk(clk), .rst(rst), .enable(enable),
    .mode(s_mode), .ctl(s_ctl), .hsync(s_hs), .vsync(s_vs),
    .pix_x(s_px), .pix_y(s_py), .frame_start(s_fs)
  );

  int total = 0;
  int bad   = 0;
  int p_d   = 0;   // linear index of the next pixel u_dut will show
  int p_s   = 0;
  int s_pg  = 0;   // preamble/guard cycles seen on u_small
  int s_ctl_nz = 0;
  vec_t tbl[$];

  // scoreboard
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: period rules applied to a pixel index
  function automatic exp_t ref_out(input timing_t t, input int p, input bit en);
    exp_t r;
    int x, y;
    bit nxt;
    x = p % t.ht;
    y = p / t.ht;
    r.px = x; r.py = y; r.en = en;
    r.mode = 2'd0; r.ctl = 4'd0; r.hs = 1'b0; r.vs = 1'b0; r.fs = 1'b0;
    if (en) begin
      r.hs = (x >= t.hs0) && (x < t.hs1);
      r.vs = (y >= t.vs0) && (y < t.vs1);
      r.fs = (p == 0);
      nxt  = ((y + 1) % t.vt) < t.va;
      if (x < t.ha && y < t.va) r.mode = 2'd3;
      else if (GB && nxt && x >= t.ht - 10 && x <= t.ht - 3) begin
        r.mode = 2'd1; r.ctl = 4'b0001;
      end else if (GB && nxt && x >= t.ht - 2) r.mode = 2'd2;
    end
    return r;
  endfunction

  function automatic void add_vec(input int inst, input int x, input int y,
                                  input logic [1:0] m, input logic [3:0] c,
                                  input logic hs, input logic vs);
    vec_t v;
    v = '{inst, x, y, m, c, hs, vs, 0};
    tbl.push_back(v);
  endfunction

  task automatic cmp_out(input string tag, input exp_t e, input logic [1:0] m,
                         input logic [3:0] c, input logic hs, input logic vs,
                         input logic fs, input logic [9:0] px, input logic [9:0] py);
    check({tag, "_mode"}, int'(m), int'(e.mode));
    check({tag, "_ctl"}, int'(c), int'(e.ctl));
    check({tag, "_hsync"}, int'(hs), int'(e.hs));
    check({tag, "_vsync"}, int'(vs), int'(e.vs));
    check({tag, "_frame_start"}, int'(fs), int'(e.fs));
    check({tag, "_pix_x"}, int'(px), e.px);
    check({tag, "_pix_y"}, int'(py), e.py);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_d_mode"}, int'(d_mode), 0);
    check({tag, "_d_ctl"}, int'(d_ctl), 0);
    check({tag, "_d_sync"}, int'({d_hs, d_vs, d_fs}), 0);
    check({tag, "_d_pix"}, int'({d_px, d_py}), 0);
    check({tag, "_s_mode"}, int'(s_mode), 0);
    check({tag, "_s_sync"}, int'({s_hs, s_vs, s_fs}), 0);
    check({tag, "_s_pix"}, int'({s_px, s_py}), 0);
  endtask

  // driver: one pixel clock with the given enable, then compare
  task automatic step(input bit en);
    exp_t ed, es;
    enable = en;
    ed = ref_out(TD, p_d, en);
    es = ref_out(TS, p_s, en);
    if (en) begin
      p_d = (p_d + 1) % (TD.ht * TD.vt);
      p_s = (p_s + 1) % (TS.ht * TS.vt);
    end
    @(posedge clk);
    @(negedge clk);
    cmp_out("d", ed, d_mode, d_ctl, d_hs, d_vs, d_fs, d_px, d_py);
    cmp_out("s", es, s_mode, s_ctl, s_hs, s_vs, s_fs, s_px, s_py);
    if (s_mode == 2'd1 || s_mode == 2'd2) s_pg++;
    if (s_ctl != 4'd0) s_ctl_nz++;
    for (int i = 0; i < tbl.size(); i++) begin
      exp_t e;
      e = (tbl[i].inst == 0) ? ed : es;
      if (e.en && e.px == tbl[i].x && e.py == tbl[i].y) begin
        string nm;
        nm = $sformatf("vec%0d_i%0d_x%0d_y%0d", i, tbl[i].inst, tbl[i].x, tbl[i].y);
        tbl[i].hits++;
        if (tbl[i].inst == 0) begin
          check({nm, "_mode"}, int'(d_mode), int'(tbl[i].mode));
          check({nm, "_ctl"}, int'(d_ctl), int'(tbl[i].ctl));
          check({nm, "_sync"}, int'({d_hs, d_vs}), int'({tbl[i].hs, tbl[i].vs}));
        end else begin
          check({nm, "_mode"}, int'(s_mode), int'(tbl[i].mode));
          check({nm, "_ctl"}, int'(s_ctl), int'(tbl[i].ctl));
          check({nm, "_sync"}, int'({s_hs, s_vs}), int'({tbl[i].hs, tbl[i].vs}));
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] pm, gm;
    logic [3:0] pc;
    int cnt;
    pm = GB ? 2'd1 : 2'd0;
    gm = GB ? 2'd2 : 2'd0;
    pc = GB ? 4'b0001 : 4'b0000;

    // default raster: line 5 leads into active line 6; syncs on line 3
    add_vec(0, 789, 5, 2'd0, 4'd0, 1'b0, 1'b0);
    add_vec(0, 790, 5, pm, pc, 1'b0, 1'b0);
    add_vec(0, 797, 5, pm, pc, 1'b0, 1'b0);
    add_vec(0, 798, 5, gm, 4'd0, 1'b0, 1'b0);
    add_vec(0, 799, 5, gm, 4'd0, 1'b0, 1'b0);
    add_vec(0, 0, 6, 2'd3, 4'd0, 1'b0, 1'b0);
    add_vec(0, 639, 6, 2'd3, 4'd0, 1'b0, 1'b0);
    add_vec(0, 640, 6, 2'd0, 4'd0, 1'b0, 1'b0);
    add_vec(0, 655, 3, 2'd0, 4'd0, 1'b0, 1'b0);
    add_vec(0, 656, 3, 2'd0, 4'd0, 1'b1, 1'b0);
    add_vec(0, 751, 3, 2'd0, 4'd0, 1'b1, 1'b0);
    add_vec(0, 752, 3, 2'd0, 4'd0, 1'b0, 1'b0);
    // small raster: last active line 5, blank line 8, last line 9 wraps to 0
    add_vec(1, 22, 5, 2'd0, 4'd0, 1'b1, 1'b0);
    add_vec(1, 22, 8, 2'd0, 4'd0, 1'b1, 1'b1);
    add_vec(1, 22, 9, pm, pc, 1'b1, 1'b0);
    add_vec(1, 29, 9, pm, pc, 1'b0, 1'b0);
    add_vec(1, 30, 9, gm, 4'd0, 1'b0, 1'b0);
    add_vec(1, 31, 9, gm, 4'd0, 1'b0, 1'b0);
    add_vec(1, 21, 0, 2'd0, 4'd0, 1'b1, 1'b0);
    add_vec(1, 22, 0, pm, pc, 1'b1, 1'b0);
    add_vec(1, 15, 5, 2'd3, 4'd0, 1'b0, 1'b0);
    add_vec(1, 16, 5, 2'd0, 4'd0, 1'b0, 1'b0);
    add_vec(1, 0, 6, 2'd0, 4'd0, 1'b0, 1'b0);
    add_vec(1, 0, 7, 2'd0, 4'd0, 1'b0, 1'b1);

    // reset held across clock edges
    repeat (3) @(negedge clk);
    check_reset("reset_hold");

    // release with enable high: first output is (0,0) video with frame_start
    enable = 1'b1;
    rst = 1'b0;
    step(1'b1);
    check("first_d_mode", int'(d_mode), 3);
    check("first_d_fs", int'(d_fs), 1);
    check("first_s_fs", int'(s_fs), 1);

    // pause for 7 cycles while pix_x=100 is showing
    repeat (100) step(1'b1);
    check("pre_pause_x", int'(d_px), 100);
    repeat (7) begin
      step(1'b0);
      check("pause_mode", int'(d_mode), 0);
      check("pause_sync", int'({d_hs, d_vs}), 0);
    end
    step(1'b1);
    check("resume_x", int'(d_px), 101);
    check("resume_mode", int'(d_mode), 3);

    // random enable until u_dut shows (795,10), mid-preamble of line 10
    while (p_d != 10 * 800 + 796) step($urandom_range(0, 15) != 0);
    check("pre_rst_mode", int'(d_mode), int'(pm));

    // asynchronous reset away from any clock edge
    #2 rst = 1'b1;
    #1 check_reset("async_rst");
    @(negedge clk);
    rst = 1'b0;
    p_d = 0;
    p_s = 0;
    step(1'b1);
    check("rerst_d_mode", int'(d_mode), 3);
    check("rerst_d_fs", int'(d_fs), 1);
    check("rerst_d_x", int'(d_px), 0);

    // two full small frames at constant enable: period and period-type counts
    s_pg = 0;
    s_ctl_nz = 0;
    repeat (2) begin
      cnt = 0;
      do begin
        step(1'b1);
        cnt++;
      end while (!s_fs && cnt < 1000);
      check("s_frame_period", cnt, TS.ht * TS.vt);
    end
    check("s_pre_guard_cycles", s_pg, GB ? 120 : 0);
    check("s_ctl_nonzero_cycles", s_ctl_nz, GB ? 96 : 0);

    for (int i = 0; i < tbl.size(); i++)
      check($sformatf("vec%0d_hit", i), int'(tbl[i].hits > 0), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
